// File: rtl/ppm16_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ppm16_rx_ctrl_if
// Purpose  : Demodulator control/data signals and the byte valid/ready sink.
// Revision : 1.0
// ============================================================================
interface ppm16_rx_ctrl_if #(
  parameter int CHIP_BITS = 4
);
  logic                 demod_resetn;
  logic                 demod_rx_start;
  logic [CHIP_BITS-1:0] demod_threshold;
  logic                 packet_detected;
  logic                 dout_valid;
  logic [3:0]           dout;
  logic                 byte_valid;
  logic                 byte_ready;
  logic [7:0]           byte_data;

  modport master (
    output demod_resetn, demod_rx_start, demod_threshold, byte_valid, byte_data,
    input  packet_detected, dout_valid, dout, byte_ready
  );

  modport slave (
    input  demod_resetn, demod_rx_start, demod_threshold, byte_valid, byte_data,
    output packet_detected, dout_valid, dout, byte_ready
  );
endinterface
`default_nettype wire

// File: rtl/ppm16_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ppm16_rx_ctrl
// Purpose  : Receive sequencer for ppm16_demod: arm/reset, timed preamble
//            search, nibble-to-byte packing, done/error status.
//            Optional: PPM16_RX_CTRL_AUTORETRY_EN (re-arm after search timeout).
// Revision : 1.0
// ============================================================================
module ppm16_rx_ctrl #(
  parameter int CHIP_BITS  = 4,
  parameter int TO_BITS    = 16,
  parameter int RST_CYCLES = 2,
  parameter int RETRY_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [CHIP_BITS-1:0]  cfg_threshold,
  input  logic [TO_BITS-1:0]    cfg_timeout,
  input  logic [RETRY_BITS-1:0] cfg_max_retries,
  ppm16_rx_ctrl_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  err_overflow,
  output logic                  odd_nibble
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_START  = 3'd2,
    S_SEARCH = 3'd3,
    S_RECV   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  state_t               state;
  logic [RST_W-1:0]     rst_cnt;
  logic [TO_BITS-1:0]   timer;
  logic [TO_BITS-1:0]   timeout_lat;
  logic [CHIP_BITS-1:0] thr_lat;
  logic                 resetn_reg;
  logic                 rx_start_reg;
  logic                 done_reg;
  logic                 half;
  logic [3:0]           hi_nib;
  logic                 byte_valid_reg;
  logic [7:0]           byte_data_reg;

  logic                 arm_ok;
  logic                 timeout_hit;
  logic                 complete;
  logic                 pad;
  logic [7:0]           new_byte;

`ifdef PPM16_RX_CTRL_AUTORETRY_EN
  logic [RETRY_BITS-1:0] retry_cnt;
  logic [RETRY_BITS-1:0] max_retries_lat;
`else
  logic unused_cfg;
  assign unused_cfg = ^cfg_max_retries;
`endif

  assign arm_ok      = (state == S_IDLE) && arm && !abort;
  assign timeout_hit = (timeout_lat != '0) && (timer == timeout_lat - 1'b1);

  // Byte completion: a normal odd nibble, or a half byte flushed by the packet end.
  always_comb begin
    complete = 1'b0;
    pad      = 1'b0;
    new_byte = 8'h00;
    if (state == S_RECV && !abort) begin
      if (bus.dout_valid && half) begin
        complete = 1'b1;
        new_byte = {hi_nib, bus.dout};
      end else if (!bus.packet_detected && bus.dout_valid) begin
        complete = 1'b1;
        pad      = 1'b1;
        new_byte = {bus.dout, 4'h0};
      end else if (!bus.packet_detected && half) begin
        complete = 1'b1;
        pad      = 1'b1;
        new_byte = {hi_nib, 4'h0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rst_cnt      <= '0;
      timer        <= '0;
      timeout_lat  <= '0;
      thr_lat      <= '0;
      resetn_reg   <= 1'b1;
      rx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      half         <= 1'b0;
      hi_nib       <= 4'h0;
      err_timeout  <= 1'b0;
      odd_nibble   <= 1'b0;
`ifdef PPM16_RX_CTRL_AUTORETRY_EN
      retry_cnt       <= '0;
      max_retries_lat <= '0;
`endif
    end else begin
      rx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        resetn_reg <= 1'b0;
        half       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            resetn_reg <= 1'b1;
            if (arm_ok) begin
              state       <= S_RST;
              resetn_reg  <= 1'b0;
              rst_cnt     <= '0;
              thr_lat     <= cfg_threshold;
              timeout_lat <= cfg_timeout;
              err_timeout <= 1'b0;
              odd_nibble  <= 1'b0;
              half        <= 1'b0;
`ifdef PPM16_RX_CTRL_AUTORETRY_EN
              retry_cnt       <= '0;
              max_retries_lat <= cfg_max_retries;
`endif
            end
          end
          S_RST: begin
            if (rst_cnt == RST_LAST) begin
              state        <= S_START;
              resetn_reg   <= 1'b1;
              rx_start_reg <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt + 1'b1;
            end
          end
          S_START: begin
            state <= S_SEARCH;
            timer <= '0;
          end
          S_SEARCH: begin
            timer <= timer + 1'b1;
            if (bus.packet_detected) begin
              state <= S_RECV;
              half  <= 1'b0;
            end else if (timeout_hit) begin
`ifdef PPM16_RX_CTRL_AUTORETRY_EN
              if (retry_cnt < max_retries_lat) begin
                retry_cnt  <= retry_cnt + 1'b1;
                state      <= S_RST;
                resetn_reg <= 1'b0;
                rst_cnt    <= '0;
              end else begin
                err_timeout <= 1'b1;
                state       <= S_IDLE;
              end
`else
              err_timeout <= 1'b1;
              state       <= S_IDLE;
`endif
            end
          end
          S_RECV: begin
            if (bus.dout_valid) begin
              hi_nib <= bus.dout;
              half   <= ~half;
            end
            // Falling packet_detected ends the packet; any pending half is flushed by pad.
            if (!bus.packet_detected) begin
              state    <= S_FIN;
              done_reg <= 1'b1;
              half     <= 1'b0;
              if (pad) odd_nibble <= 1'b1;
            end
          end
          S_FIN: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Output byte register lives independently of the FSM so it survives abort/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_valid_reg <= 1'b0;
      byte_data_reg  <= 8'h00;
      err_overflow   <= 1'b0;
    end else begin
      if (arm_ok) err_overflow <= 1'b0;
      if (complete) begin
        if (byte_valid_reg && !bus.byte_ready) begin
          err_overflow <= 1'b1;
        end else begin
          byte_valid_reg <= 1'b1;
          byte_data_reg  <= new_byte;
        end
      end else if (byte_valid_reg && bus.byte_ready) begin
        byte_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.demod_resetn    = resetn_reg;
  assign bus.demod_rx_start  = rx_start_reg;
  assign bus.demod_threshold = thr_lat;
  assign bus.byte_valid      = byte_valid_reg;
  assign bus.byte_data       = byte_data_reg;
  assign busy                = (state != S_IDLE);
  assign done                = done_reg;

endmodule
`default_nettype wire

// File: tb/tb_ppm16_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppm16_rx_ctrl
// Purpose  : Self-checking bench for ppm16_rx_ctrl: table vectors, corner
//            sequences and randomized packets against a nibble-pairing model.
// Revision : 1.0
// ============================================================================
module tb_ppm16_rx_ctrl;

  logic       clk;
  logic       reset;
  logic       arm;
  logic       abort;
  logic [3:0] cfg_threshold;
  logic [15:0] cfg_timeout;
  logic [2:0] cfg_max_retries;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       err_overflow;
  logic       odd_nibble;

  ppm16_rx_ctrl_if #(.CHIP_BITS(4)) bus ();

  ppm16_rx_ctrl #(
    .CHIP_BITS(4), .TO_BITS(16), .RST_CYCLES(2), .RETRY_BITS(3)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .cfg_threshold(cfg_threshold), .cfg_timeout(cfg_timeout),
    .cfg_max_retries(cfg_max_retries), .bus(bus), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_overflow(err_overflow), .odd_nibble(odd_nibble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int done_cnt;
  int start_cnt;
  logic [7:0] got[$];

  // Handshake/pulse monitor sampled mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_data);
    if (done) done_cnt++;
    if (bus.demod_rx_start) start_cnt++;
  end

  typedef struct {
    logic [3:0]  thr;
    int          n;
    logic [31:0] nibs;
    int          nb;
    logic [31:0] bytes;
    logic        odd;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_arm(input logic [3:0] thr, input logic [15:0] to, input logic [2:0] mr);
    cfg_threshold   = thr;
    cfg_timeout     = to;
    cfg_max_retries = mr;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    cfg_threshold   = ~thr;
    cfg_timeout     = 16'd1;
    cfg_max_retries = 3'd0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20; i++) begin
      if (bus.demod_rx_start) break;
      tick();
    end
    chk("rx_start_seen", bus.demod_rx_start, 1);
  endtask

  task automatic nib(input logic [3:0] v);
    bus.dout_valid = 1'b1;
    bus.dout       = v;
    tick();
    bus.dout_valid = 1'b0;
  endtask

  task automatic run_packet(input logic [3:0] thr, input logic [15:0] to, input int delay,
                            input int n, input logic [31:0] nibs, input bit gaps,
                            input bit last_on_fall);
    got.delete();
    done_cnt = 0;
    do_arm(thr, to, 3'd0);
    wait_start();
    tick();
    repeat (delay) tick();
    bus.packet_detected = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      bus.dout_valid = 1'b1;
      bus.dout       = nibs[31-4*i -: 4];
      if (i == n - 1 && last_on_fall) bus.packet_detected = 1'b0;
      tick();
      bus.dout_valid = 1'b0;
    end
    bus.packet_detected = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    logic [3:0]  r_thr;
    logic [15:0] r_to;
    logic [31:0] r_nibs;
    int          r_n;
    int          r_delay;
    logic [7:0]  exp_q[$];

    n_checks = 0; n_fail = 0; done_cnt = 0; start_cnt = 0;
    reset = 1'b1; arm = 1'b0; abort = 1'b0;
    cfg_threshold = 4'h0; cfg_timeout = 16'h0; cfg_max_retries = 3'h0;
    bus.packet_detected = 1'b0; bus.dout_valid = 1'b0; bus.dout = 4'h0; bus.byte_ready = 1'b1;

    vecs[0] = '{4'h3, 4, 32'hA53C_0000, 2, 32'hA53C_0000, 1'b0};
    vecs[1] = '{4'h9, 3, 32'h1230_0000, 2, 32'h1230_0000, 1'b1};
    vecs[2] = '{4'hF, 1, 32'h7000_0000, 1, 32'h7000_0000, 1'b1};
    vecs[3] = '{4'h0, 0, 32'h0000_0000, 0, 32'h0000_0000, 1'b0};
    vecs[4] = '{4'h6, 5, 32'hF0E1_D000, 3, 32'hF0E1_D000, 1'b1};

    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_resetn", bus.demod_resetn, 1);
    chk("rst_rx_start", bus.demod_rx_start, 0);
    chk("rst_thr", bus.demod_threshold, 0);
    chk("rst_byte", {bus.byte_valid, bus.byte_data}, 0);
    chk("rst_status", {busy, done, err_timeout, err_overflow, odd_nibble}, 0);

    // Basic packet with exact arm/reset/start timing.
    got.delete(); done_cnt = 0;
    do_arm(4'd3, 16'd100, 3'd0);
    chk("t1_resetn_c1", bus.demod_resetn, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_resetn_c2", bus.demod_resetn, 0);
    chk("t1_start_early", bus.demod_rx_start, 0);
    tick();
    chk("t1_resetn_hi", bus.demod_resetn, 1);
    chk("t1_rx_start", bus.demod_rx_start, 1);
    chk("t1_thr", bus.demod_threshold, 3);
    tick();
    chk("t1_start_1cyc", bus.demod_rx_start, 0);
    repeat (16) tick();
    bus.packet_detected = 1'b1;
    tick();
    nib(4'hA);
    nib(4'h5);
    chk("t1_bv_latency", bus.byte_valid, 1);
    chk("t1_b0_reg", bus.byte_data, 8'hA5);
    nib(4'h3);
    nib(4'hC);
    chk("t1_b1_reg", bus.byte_data, 8'h3C);
    bus.packet_detected = 1'b0;
    tick();
    chk("t1_done", done, 1);
    tick();
    chk("t1_done_1cyc", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_nbytes", got.size(), 2);
    if (got.size() == 2) begin
      chk("t1_b0", got[0], 8'hA5);
      chk("t1_b1", got[1], 8'h3C);
    end

    // Search timeout.
    do_arm(4'd0, 16'd10, 3'd0);
    repeat (12) tick();
    chk("t2_no_to_yet", err_timeout, 0);
    chk("t2_busy", busy, 1);
    tick();
    chk("t2_timeout", err_timeout, 1);
    chk("t2_idle", busy, 0);

    // Packet and timeout in the same cycle: packet wins; arm cleared the flag.
    run_packet(4'd5, 16'd5, 4, 2, 32'h9100_0000, 1'b0, 1'b0);
    chk("t2b_flag_clear", err_timeout, 0);
    chk("t2b_done", done_cnt, 1);
    chk("t2b_nbytes", got.size(), 1);
    if (got.size() == 1) chk("t2b_b0", got[0], 8'h91);

    // Overflow: sink stalled across two completed bytes.
    bus.byte_ready = 1'b0;
    run_packet(4'd2, 16'd0, 0, 4, 32'h1234_0000, 1'b0, 1'b0);
    chk("t4_bv_held", bus.byte_valid, 1);
    chk("t4_first_kept", bus.byte_data, 8'h12);
    chk("t4_overflow", err_overflow, 1);
    chk("t4_odd", odd_nibble, 0);
    chk("t4_done", done_cnt, 1);
    bus.byte_ready = 1'b1;
    tick();
    chk("t4_nbytes", got.size(), 1);
    if (got.size() == 1) chk("t4_b0", got[0], 8'h12);
    chk("t4_bv_clr", bus.byte_valid, 0);

    // Retry on timeout (one attempt only unless auto-retry is built in).
    start_cnt = 0;
    do_arm(4'd1, 16'd8, 3'd2);
    chk("t6_ovf_clear", err_overflow, 0);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    chk("t6_idle", busy, 0);
`ifdef PPM16_RX_CTRL_AUTORETRY_EN
    chk("t6_starts", start_cnt, 3);
`else
    chk("t6_starts", start_cnt, 1);
`endif
    chk("t6_timeout", err_timeout, 1);

    // Abort in RECV after one nibble.
    got.delete(); done_cnt = 0;
    do_arm(4'd4, 16'd0, 3'd0);
    chk("t5_to_clear", err_timeout, 0);
    wait_start();
    tick();
    bus.packet_detected = 1'b1;
    tick();
    nib(4'h7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.packet_detected = 1'b0;
    chk("t5_idle", busy, 0);
    chk("t5_resetn_lo", bus.demod_resetn, 0);
    tick();
    chk("t5_resetn_hi", bus.demod_resetn, 1);
    repeat (3) tick();
    chk("t5_no_done", done_cnt, 0);
    chk("t5_no_byte", got.size(), 0);

    for (int v = 0; v < 5; v++) begin
      run_packet(vecs[v].thr, 16'd0, 2, vecs[v].n, vecs[v].nibs, 1'b0, 1'b0);
      chk("tbl_nbytes", got.size(), vecs[v].nb);
      for (int j = 0; j < vecs[v].nb && j < got.size(); j++)
        chk("tbl_byte", got[j], vecs[v].bytes[31-8*j -: 8]);
      chk("tbl_odd", odd_nibble, vecs[v].odd);
      chk("tbl_done", done_cnt, 1);
      chk("tbl_thr", bus.demod_threshold, vecs[v].thr);
      chk("tbl_idle", busy, 0);
    end

    for (int it = 0; it < 25; it++) begin
      r_thr   = 4'($urandom);
      r_delay = $urandom_range(0, 10);
      r_to    = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(r_delay + 1 + $urandom_range(0, 20));
      r_n     = $urandom_range(0, 8);
      r_nibs  = 32'h0;
      for (int i = 0; i < r_n; i++) r_nibs[31-4*i -: 4] = 4'($urandom);
      // Model: consecutive nibble pairs form bytes, a lone trailing nibble gets a zero low half.
      exp_q.delete();
      for (int j = 0; j < r_n; j += 2)
        exp_q.push_back(8'((r_nibs >> (24 - 4*j)) & 32'hFF));
      run_packet(r_thr, r_to, r_delay, r_n, r_nibs, 1'b1, (r_n > 0) && ($urandom_range(0, 1) == 1));
      chk("rnd_nbytes", got.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < got.size(); j++)
        chk("rnd_byte", got[j], exp_q[j]);
      chk("rnd_odd", odd_nibble, r_n % 2);
      chk("rnd_done", done_cnt, 1);
      chk("rnd_thr", bus.demod_threshold, r_thr);
      chk("rnd_flags", {err_timeout, err_overflow, busy}, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
